// File: rtl/genclk_multi.sv
// Multi-channel runtime-programmable clock/tick divider off CLK50M; toggle-clock or strobe output per channel.
// Latency: all outputs registered, tc visible one cycle after the edge; no backpressure, divisor writes always accepted.
module genclk_multi #(
   parameter int          NCH     = 4,
   parameter int          CW      = 16,
   parameter int unsigned DIV_RST = 24999,
   localparam int         SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           CLK50M,
   input  logic           RST,
   input  logic [NCH-1:0] EN,
   input  logic [NCH-1:0] MODE,
   input  logic           WR,
   input  logic [SW-1:0]  WSEL,
   input  logic [CW-1:0]  WDATA,
   input  logic           SYNC,
   output logic [NCH-1:0] CLKOUT,
   output logic [NCH-1:0] TICK,
   output logic [NCH-1:0] PEND
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic [CW-1:0] diva;
      logic [CW-1:0] shdw;
      logic          clk_q;
      logic          tick_q;
      logic          pend_q;
      logic          tc;
      logic          wr_hit;
      logic          restart;

      // Out-of-range WSEL matches no channel, so such writes fall away.
      assign wr_hit  = WR && (32'(WSEL) == i);
      assign tc      = EN[i] && (cnt == diva);
      assign restart = SYNC || !EN[i] || tc;

      always_ff @(posedge CLK50M or posedge RST) begin
         if (RST) begin
            cnt    <= '0;
            diva   <= CW'(DIV_RST);
            shdw   <= CW'(DIV_RST);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
         end else begin
            if (wr_hit) begin
               shdw <= WDATA;
            end
            // Period boundary: the shadow value from before this edge becomes active,
            // and a write landing on the same edge stays pending for the next boundary.
            if (restart) begin
               cnt    <= '0;
               diva   <= shdw;
               pend_q <= wr_hit;
               tick_q <= tc && !SYNC;
               clk_q  <= (tc && !SYNC) ? (MODE[i] | ~clk_q) : 1'b0;
            end else begin
               cnt    <= cnt + 1'b1;
               pend_q <= pend_q | wr_hit;
               tick_q <= 1'b0;
               clk_q  <= clk_q & ~MODE[i];
            end
         end
      end

      assign CLKOUT[i] = clk_q;
      assign TICK[i]   = tick_q;
      assign PEND[i]   = pend_q;
   end

endmodule

// File: tb/tb_genclk_multi.sv
// Directed bench for genclk_multi: per-cycle vector table plus hand-written SYNC, write/tc, enable, D=0 and reset sequences.
// A small second instance exercises out-of-range write selects.
module tb_genclk_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en, mode;
   logic        wr, sync;
   logic [1:0]  wsel;
   logic [15:0] wdata;
   logic [3:0]  clkout, tick, pend;

   logic        wr_s, sync_s;
   logic [2:0]  en_s, mode_s;
   logic [1:0]  wsel_s;
   logic [7:0]  wdata_s;
   logic [2:0]  clkout_s, tick_s, pend_s;

   int n_chk = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   genclk_multi u_dut (
      .CLK50M(clk), .RST(rst), .EN(en), .MODE(mode), .WR(wr), .WSEL(wsel),
      .WDATA(wdata), .SYNC(sync), .CLKOUT(clkout), .TICK(tick), .PEND(pend)
   );

   genclk_multi #(.NCH(3), .CW(8), .DIV_RST(2)) u_small (
      .CLK50M(clk), .RST(rst), .EN(en_s), .MODE(mode_s), .WR(wr_s), .WSEL(wsel_s),
      .WDATA(wdata_s), .SYNC(sync_s), .CLKOUT(clkout_s), .TICK(tick_s), .PEND(pend_s)
   );

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  mode;
      logic        wr;
      logic [1:0]  wsel;
      logic [15:0] wdata;
      logic        sync;
      logic [3:0]  e_clk;
      logic [3:0]  e_tick;
      logic [3:0]  e_pend;
   } vec_t;

   vec_t vt [27];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Setup with channels idle (writes apply immediately), then free-run:
      // ch0 D=2 toggle, ch1 D=5 toggle, ch2 D=4 pulse, ch3 D=3 toggle; ch1 rewritten to D=3 mid-period.
      vt[0]  = '{4'b0000, 4'b0100, 1'b1, 2'd0, 16'd2, 1'b0, 4'b0000, 4'b0000, 4'b0001};
      vt[1]  = '{4'b0000, 4'b0100, 1'b1, 2'd1, 16'd5, 1'b0, 4'b0000, 4'b0000, 4'b0010};
      vt[2]  = '{4'b0000, 4'b0100, 1'b1, 2'd2, 16'd4, 1'b0, 4'b0000, 4'b0000, 4'b0100};
      vt[3]  = '{4'b0000, 4'b0100, 1'b1, 2'd3, 16'd3, 1'b0, 4'b0000, 4'b0000, 4'b1000};
      vt[4]  = '{4'b0000, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vt[5]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vt[6]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
      vt[7]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0001, 4'b0000};
      vt[8]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1001, 4'b1000, 4'b0000};
      vt[9]  = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1101, 4'b0100, 4'b0000};
      vt[10] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1010, 4'b0011, 4'b0000};
      vt[11] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1010, 4'b0000, 4'b0000};
      vt[12] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b1000, 4'b0000};
      vt[13] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0011, 4'b0001, 4'b0000};
      vt[14] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0111, 4'b0100, 4'b0000};
      vt[15] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0011, 4'b0000, 4'b0000};
      vt[16] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1000, 4'b1011, 4'b0000};
      vt[17] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1000, 4'b0000, 4'b0000};
      vt[18] = '{4'b1111, 4'b0100, 1'b1, 2'd1, 16'd3, 1'b0, 4'b1000, 4'b0000, 4'b0010};
      vt[19] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1101, 4'b0101, 4'b0010};
      vt[20] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b1000, 4'b0010};
      vt[21] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0000, 4'b0010};
      vt[22] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0011, 4'b0000};
      vt[23] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0000, 4'b0000};
      vt[24] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1110, 4'b1100, 4'b0000};
      vt[25] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1011, 4'b0001, 4'b0000};
      vt[26] = '{4'b1111, 4'b0100, 1'b0, 2'd0, 16'd0, 1'b0, 4'b1001, 4'b0010, 4'b0000};

      rst = 1'b1; en = '0; mode = '0; wr = 1'b0; sync = 1'b0; wsel = '0; wdata = '0;
      en_s = 3'b111; mode_s = '0; wr_s = 1'b0; sync_s = 1'b0; wsel_s = '0; wdata_s = '0;
      step();
      step();
      chk("rst_clkout", clkout, 4'b0000);
      chk("rst_tick", tick, 4'b0000);
      chk("rst_pend", pend, 4'b0000);
      rst = 1'b0;

      // Small instance (NCH=3, D=2): WSEL=3 write must be ignored.
      sync_s = 1'b1;
      step();
      chk("s_sync_clk", clkout_s, 3'b000);
      sync_s = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         wr_s = (k == 1); wsel_s = 2'd3; wdata_s = 8'd0;
         step();
         if (k == 1) chk("s_oor_pend", pend_s, 3'b000);
         chk($sformatf("s_tick_k%0d", k), tick_s, (k % 3 == 0) ? 3'b111 : 3'b000);
         chk($sformatf("s_clk_k%0d", k), clkout_s, ((k / 3) % 2 == 1) ? 3'b111 : 3'b000);
      end
      wr_s = 1'b1; wsel_s = 2'd2;
      step();
      chk("s_inrange_pend", pend_s, 3'b100);
      wr_s = 1'b0;

      for (int i = 0; i < 27; i++) begin
         en = vt[i].en; mode = vt[i].mode; wr = vt[i].wr; wsel = vt[i].wsel;
         wdata = vt[i].wdata; sync = vt[i].sync;
         step();
         chk($sformatf("row%0d_clk", i), clkout, vt[i].e_clk);
         chk($sformatf("row%0d_tick", i), tick, vt[i].e_tick);
         chk($sformatf("row%0d_pend", i), pend, vt[i].e_pend);
      end
      wr = 1'b0;

      // SYNC: ch0 D=2, ch1 D=5 restart in phase; then a write coincident with ch0 tc.
      wr = 1'b1; wsel = 2'd1; wdata = 16'd5;
      step();
      chk("sync_pre_pend", pend, 4'b0010);
      wr = 1'b0; sync = 1'b1;
      step();
      chk("sync_clk", clkout, 4'b0000);
      chk("sync_tick", tick, 4'b0000);
      chk("sync_pend", pend, 4'b0000);
      sync = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         wr = (k == 15); wsel = 2'd0; wdata = 16'd1;
         step();
         if (k <= 12) begin
            chk($sformatf("sync_clk_k%0d", k), clkout[1:0],
                {((k / 6) % 2 == 1), ((k / 3) % 2 == 1)});
            chk($sformatf("sync_tick_k%0d", k), tick[1:0], {(k % 6 == 0), (k % 3 == 0)});
         end else begin
            chk($sformatf("wtc_tick_k%0d", k), tick[0],
                (k == 15 || k == 18 || k == 20 || k == 22));
            chk($sformatf("wtc_pend_k%0d", k), pend[0], (k >= 15 && k <= 17));
            if (k == 15) chk("wtc_clk_k15", clkout[0], 1'b1);
         end
      end
      wr = 1'b0;

      // D=0 on ch2: pulse gives constant high, toggle gives CLK50M/2.
      en = 4'b1011; wr = 1'b1; wsel = 2'd2; wdata = 16'd0;
      step();
      chk("d0_idle_pend", pend[2], 1'b1);
      chk("d0_idle_clk", clkout[2], 1'b0);
      wr = 1'b0;
      step();
      chk("d0_apply_pend", pend[2], 1'b0);
      en = 4'b1111; mode = 4'b0100;
      for (int j = 0; j < 4; j++) begin
         step();
         chk($sformatf("d0_pulse_clk%0d", j), clkout[2], 1'b1);
         chk($sformatf("d0_pulse_tick%0d", j), tick[2], 1'b1);
      end
      mode = 4'b0000;
      for (int j = 0; j < 4; j++) begin
         step();
         chk($sformatf("d0_tog_clk%0d", j), clkout[2], (j % 2 == 1));
         chk($sformatf("d0_tog_tick%0d", j), tick[2], 1'b1);
      end

      // Disable ch3 with a pending write, then re-enable with D=2.
      wr = 1'b1; wsel = 2'd3; wdata = 16'd2;
      step();
      chk("en_pend_set", pend[3], 1'b1);
      wr = 1'b0; en = 4'b0111;
      step();
      chk("en_off_pend", pend[3], 1'b0);
      chk("en_off_clk", clkout[3], 1'b0);
      chk("en_off_tick", tick[3], 1'b0);
      for (int j = 0; j < 2; j++) begin
         step();
         chk($sformatf("en_off_hold%0d", j), clkout[3], 1'b0);
      end
      en = 4'b1111;
      for (int j = 1; j <= 3; j++) begin
         step();
         chk($sformatf("reen_tick%0d", j), tick[3], (j == 3));
         chk($sformatf("reen_clk%0d", j), clkout[3], (j == 3));
      end

      // Asynchronous reset mid-period with CLKOUT high and a write pending.
      wr = 1'b1; wsel = 2'd1; wdata = 16'd7;
      step();
      wr = 1'b0;
      chk("prerst_clk3", clkout[3], 1'b1);
      chk("prerst_pend1", pend[1], 1'b1);
      #5 rst = 1'b1;
      #1;
      chk("arst_clkout", clkout, 4'b0000);
      chk("arst_tick", tick, 4'b0000);
      chk("arst_pend", pend, 4'b0000);
      en = 4'b1111; mode = 4'b0000;
      step();
      step();
      rst = 1'b0;

      // Defaults after reset: D=24999 toggle on every channel.
      begin
         int   first_rise = 0, fall = 0, t1 = 0, t2 = 0, ntick = 0, pend_seen = 0;
         logic prev0 = 1'b0;
         logic [3:0] rise_vec = '0;
         for (int c = 1; c <= 50000; c++) begin
            step();
            if (clkout[0] && !prev0 && first_rise == 0) begin
               first_rise = c;
               rise_vec   = clkout;
            end
            if (!clkout[0] && prev0 && fall == 0) fall = c;
            if (tick[0]) begin
               ntick++;
               if (ntick == 1) t1 = c;
               else if (ntick == 2) t2 = c;
            end
            if (pend != 4'b0000) pend_seen++;
            prev0 = clkout[0];
         end
         chk("dflt_first_rise", first_rise, 25000);
         chk("dflt_rise_all", rise_vec, 4'b1111);
         chk("dflt_fall", fall, 50000);
         chk("dflt_tick1", t1, 25000);
         chk("dflt_tick2", t2, 50000);
         chk("dflt_ntick", ntick, 2);
         chk("dflt_pend", pend_seen, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
